// File: rtl/serial_operand_serializer.sv
// Double-buffered operand serializer feeding a 1-bit serial adder.
// Streams A/B LSB-first with a carry-clear strobe on MSB and idle cycles.
module serial_operand_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             carry_clr
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    typedef enum logic {StEmpty, StFull} stage_e;

    stage_e           sh_state_q, sh_state_d;
    stage_e           hd_state_q, hd_state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [WIDTH-1:0] hd_a_q, hd_a_d, hd_b_q, hd_b_d;
    logic [IdxW-1:0]  idx_q, idx_d;

    logic sh_valid, hd_valid, done, accept;

    assign sh_valid = (sh_state_q == StFull);
    assign hd_valid = (hd_state_q == StFull);
    assign done     = sh_valid & (idx_q == IdxLast);
    assign accept   = in_valid & ~hd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_state_q <= StEmpty;
            hd_state_q <= StEmpty;
            sh_a_q     <= '0;
            sh_b_q     <= '0;
            hd_a_q     <= '0;
            hd_b_q     <= '0;
            idx_q      <= '0;
        end else begin
            sh_state_q <= sh_state_d;
            hd_state_q <= hd_state_d;
            sh_a_q     <= sh_a_d;
            sh_b_q     <= sh_b_d;
            hd_a_q     <= hd_a_d;
            hd_b_q     <= hd_b_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        sh_state_d = sh_state_q;
        hd_state_d = hd_state_q;
        sh_a_d     = sh_a_q;
        sh_b_d     = sh_b_q;
        hd_a_d     = hd_a_q;
        hd_b_d     = hd_b_q;
        idx_d      = idx_q;
        if (!sh_valid || done) begin
            idx_d = '0;
            if (hd_valid) begin
                sh_state_d = StFull;
                hd_state_d = StEmpty;
                sh_a_d     = hd_a_q;
                sh_b_d     = hd_b_q;
            end else if (accept) begin
                // Idle bypass: the pair goes straight into the shift stage.
                sh_state_d = StFull;
                sh_a_d     = a_in;
                sh_b_d     = b_in;
            end else begin
                // Zero the data so a/b read 0 while empty.
                sh_state_d = StEmpty;
                sh_a_d     = '0;
                sh_b_d     = '0;
            end
        end else begin
            sh_a_d = {1'b0, sh_a_q[WIDTH-1:1]};
            sh_b_d = {1'b0, sh_b_q[WIDTH-1:1]};
            idx_d  = idx_q + IdxW'(1);
            if (accept) begin
                hd_state_d = StFull;
                hd_a_d     = a_in;
                hd_b_d     = b_in;
            end
        end
    end

    always_comb begin
        in_ready  = ~hd_valid;
        a         = sh_a_q[0];
        b         = sh_b_q[0];
        bit_valid = sh_valid;
        bit_last  = done;
        carry_clr = ~sh_valid | done;
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Scoreboarded bench: random and directed operand pairs, checked against
// word-level A/B/sum expectations and a serial adder reference.
module tb_serial_operand_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_in, b_in;
    logic         in_valid;
    logic         in_ready, a, b, bit_valid, bit_last, carry_clr;

    logic [1:0] a_in2, b_in2;
    logic       in_valid2;
    logic       in_ready2, a2, b2, bit_valid2, bit_last2, carry_clr2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int max_run = 0;

    logic [2*W-1:0] exp_q[$];
    int             acc_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_operand_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .bit_valid(bit_valid),
        .bit_last(bit_last), .carry_clr(carry_clr)
    );

    serial_operand_serializer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .a_in(a_in2), .b_in(b_in2), .in_valid(in_valid2),
        .in_ready(in_ready2), .a(a2), .b(b2), .bit_valid(bit_valid2),
        .bit_last(bit_last2), .carry_clr(carry_clr2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
        bit acc = 1'b0;
        a_in = av;
        b_in = bv;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back({av, bv});
                acc_cyc.push_back(cyc);
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bit_valid) ok = 1'b1;
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: collects serial bits per word and runs a reference serial adder.
    int           cnt = 0;
    int           run = 0;
    logic         carry = 1'b0;
    logic [W-1:0] col_a, col_b, col_s;
    always @(negedge clk) begin
        logic s;
        logic [2*W-1:0] e;
        if (rst) begin
            exp_q.delete();
            cnt = 0;
            run = 0;
            carry = 1'b0;
        end else begin
            chk("carry_clr", carry_clr, !bit_valid || bit_last);
            if (!bit_valid) begin
                chk("idle_ab", {a, b}, 2'b00);
                run = 0;
            end else begin
                run++;
                if (run > max_run) max_run = run;
                chk("bit_last_pos", bit_last, cnt == W - 1);
                s = a ^ b ^ carry;
                col_a[cnt] = a;
                col_b[cnt] = b;
                col_s[cnt] = s;
                if (cnt == W - 1) begin
                    cnt = 0;
                    if (exp_q.size() == 0) begin
                        chk("word_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_a", col_a, e[2*W-1:W]);
                        chk("word_b", col_b, e[W-1:0]);
                        chk("word_sum", col_s, W'(e[2*W-1:W] + e[W-1:0]));
                    end
                end else begin
                    cnt++;
                end
            end
            carry = carry_clr ? 1'b0 : ((a & b) | (a & carry) | (b & carry));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] pa, pb;
        logic [1:0]   s2;
        logic         c2;
        rst = 1'b1;
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        in_valid2 = 1'b0;
        a_in2 = '0;
        b_in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset.
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 1);
            chk("idle_bit_valid", bit_valid, 0);
            chk("idle_carry_clr", carry_clr, 1);
        end
        @(posedge clk);
        #1;

        // Single word, bit-exact with latency 1.
        pa = 8'h5A;
        pb = 8'h3C;
        send(pa, pb);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("w1_valid", bit_valid, 1);
            chk("w1_a", a, pa[i]);
            chk("w1_b", b, pb[i]);
            chk("w1_last", bit_last, i == W - 1);
            if (i < W - 1) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Back-to-back words without bubbles.
        max_run = 0;
        send(8'hFF, 8'h01);
        send(8'h00, 8'h00);
        send(8'h12, 8'h34);
        drain();
        chk("b2b_run", max_run, 3 * W);

        // Backpressure: continuous offers.
        acc_cyc.delete();
        send(W'($urandom), W'($urandom));
        send(W'($urandom), W'($urandom));
        @(negedge clk);
        chk("bp_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom));
        for (int i = 2; i < 6; i++) chk("bp_spacing", acc_cyc[i] - acc_cyc[i-1], W);
        drain();

        // Random traffic with random gaps.
        for (int i = 0; i < 24; i++) begin
            send(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        // Reset at bit 3 with the hold stage full.
        send(8'hA5, 8'h5A);
        send(8'hC3, 8'h3C);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_carry_clr", carry_clr, 1);
        @(posedge clk);
        #1;
        send(8'h01, 8'h01);
        drain();

        // WIDTH = 2 instance.
        a_in2 = 2'h3;
        b_in2 = 2'h1;
        in_valid2 = 1'b1;
        @(negedge clk);
        chk("w2_ready", in_ready2, 1);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        c2 = 1'b0;
        s2 = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("w2_valid", bit_valid2, 1);
            chk("w2_a", a2, 1'b1);
            chk("w2_b", b2, (i == 0) ? 1'b1 : 1'b0);
            chk("w2_last", bit_last2, i == 1);
            s2[i] = a2 ^ b2 ^ c2;
            c2 = (a2 & b2) | (a2 & c2) | (b2 & c2);
            @(posedge clk);
            #1;
        end
        chk("w2_sum", s2, 2'h0);
        @(negedge clk);
        chk("w2_idle", bit_valid2, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_operand_serializer.md
# serial_operand_serializer

Upstream feeder for the 1-bit serial adder. It accepts a pair of WIDTH-bit operands over a valid/ready handshake and streams them out LSB-first, one bit per clock, on the adder's `a`/`b` inputs. It also drives a carry-clear strobe so each word starts with carry 0. Double-buffered: a new operand pair can be accepted while the current one is shifting, so back-to-back words stream with no bubble cycles.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range WIDTH ≥ 2.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_in` in WIDTH: operand A, sampled on accept.
- `b_in` in WIDTH: operand B, sampled on accept.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block can take a pair this cycle; accept = `in_valid & in_ready`.
- `a` out 1: current serial bit of A (connects to adder `a`).
- `b` out 1: current serial bit of B (connects to adder `b`).
- `bit_valid` out 1: `a`/`b` carry a real operand bit this cycle.
- `bit_last` out 1: current bit is the MSB (index WIDTH-1) of the word.
- `carry_clr` out 1: clear request for the adder carry register; the integrator ORs it with `rst` into the adder reset.

## Operation
- Storage:
  - Shift stage: `sh_a`, `sh_b`, `sh_valid`, bit counter `idx` of width $clog2(WIDTH).
  - Holding stage: `hd_a`, `hd_b`, `hd_valid`.
- `in_ready = ~hd_valid`, combinational from registered state only; it never depends on `in_valid`.
- Outputs:
  - `a = sh_a[0]` and `b = sh_b[0]`.
  - `bit_valid = sh_valid`.
  - `bit_last = sh_valid & (idx == WIDTH-1)`.
  - `carry_clr = ~sh_valid | bit_last`.
- When `sh_valid` = 0, `a` and `b` are 0.
- Per-edge behaviour, with `done = bit_last` (shift stage frees up at this edge):
  - **Shift stage empty or done, hold valid:** load shift stage from hold, `idx` = 0, clear `hd_valid`. An accept is impossible this cycle because `in_ready` = 0.
  - **Shift stage empty or done, hold empty, accept:** load shift stage directly from `a_in`/`b_in`, `idx` = 0.
  - **Shift stage empty or done, hold empty, no accept:** `sh_valid` ← 0.
  - **Shift stage busy and not done:** shift `sh_a`/`sh_b` right by one (zero-fill), `idx` ← `idx`+1. An accept in the same cycle loads the hold stage.
- Carry protocol: `carry_clr` is high during the MSB cycle and during idle cycles.
  - The adder still produces the MSB sum combinationally with the live carry.
  - Its carry register is zeroed at the closing edge.
  - The next word's bit 0 therefore always sees carry 0. Carry never leaks between words.
- Internal state is two explicit states per stage (EMPTY/FULL). The shift stage additionally has the counter; no other FSM.

## Timing
- Reset values: `in_ready` = 1, `a` = 0, `b` = 0, `bit_valid` = 0, `bit_last` = 0, `carry_clr` = 1. Both stages are empty and `idx` = 0.
- Reset mid-word: the word is discarded, nothing is resumed, and outputs take their reset values from the next cycle.
- Latency: pair accepted in cycle t (idle block) → bit 0 on `a`/`b` in cycle t+1, MSB in cycle t+WIDTH.
- Throughput: one word per WIDTH cycles.
  - Pair accepted during the previous word's MSB cycle, or already held: its bit 0 appears in the cycle right after that MSB, with no gap.
- Backpressure: with both stages full, `in_ready` = 0 until the edge that moves hold into shift; `in_ready` returns to 1 in the cycle after.
- Accept while idle and `in_ready` = 1: the pair bypasses the hold stage.
- Inputs are sampled only on accept. `a_in`/`b_in` may change freely otherwise.

## Test plan
- Reset, then idle 5 cycles → `in_ready` = 1, `bit_valid` = 0, `carry_clr` = 1 each cycle.
- WIDTH = 8, accept A = 0x5A, B = 0x3C at cycle t → cycles t+1..t+8:
  - `a` = 0,1,0,1,1,0,1,0 and `b` = 0,0,1,1,1,1,0,0.
  - `bit_last` only at t+8.
  - Reference adder output collected LSB-first = 0x96.
- Back-to-back: hold `in_valid` = 1 with pairs (0xFF,0x01), (0x00,0x00), (0x12,0x34) →
  - Collected sums are 0x00, 0x00, 0x46.
  - `bit_valid` is continuously 1 for 24 cycles.
  - `carry_clr` is high exactly at the three MSB cycles.
- Backpressure: offer pairs every cycle → `in_ready` drops after the second accept, rises once per 8 cycles, and no pair is lost or duplicated.
- `rst` asserted at bit 3 of a word with the hold stage full →
  - Next cycle: `bit_valid` = 0, `in_ready` = 1, `carry_clr` = 1.
  - A fresh pair (0x01,0x01) yields sum 0x02.
- WIDTH = 2: accepting (0x3,0x1) yields bits `a` = 1,1 and `b` = 1,0, with `bit_last` on the 2nd cycle and sum 0x0.
